// File: rtl/sram_model_param.sv
// sram_model_param: parametrised asynchronous-SRAM bus model with read wait-states, protocol checks and access counters
module sram_model_param #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 20,
  parameter int DEPTH        = 1 << ADDR_WIDTH,
  parameter int READ_LATENCY = 0,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  inout  wire  [DATA_WIDTH-1:0]   ram_data,
  input  logic [ADDR_WIDTH-1:0]   ram_addr,
  input  logic [DATA_WIDTH/8-1:0] ram_be_n,
  input  logic                    ram_ce_n,
  input  logic                    ram_oe_n,
  input  logic                    ram_we_n,
  output logic [CNT_WIDTH-1:0]    rd_count,
  output logic [CNT_WIDTH-1:0]    wr_count,
  output logic                    contention,
  output logic                    range_err
);
  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = READ_LATENCY > 1 ? $clog2(READ_LATENCY) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, DRIVE} state_t;
  state_t state, nxt_state;
  logic [ADDR_WIDTH-1:0] la, nxt_la, rd_addr;
  logic [CW-1:0] cnt, nxt_cnt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic rd_req, wr_req, clash, addr_ok, la_ok, rd_ok, fresh, drive, rd_inc;
  assign rd_req  = ~ram_ce_n & ~ram_oe_n & ram_we_n;
  assign wr_req  = ~ram_ce_n & ram_oe_n & ~ram_we_n;
  assign clash   = ~ram_ce_n & ~ram_oe_n & ~ram_we_n;
  assign addr_ok = {1'b0, ram_addr} < (ADDR_WIDTH+1)'(DEPTH);
  assign la_ok   = {1'b0, la} < (ADDR_WIDTH+1)'(DEPTH);
  assign rd_addr = READ_LATENCY == 0 ? ram_addr : la;
  assign rd_ok   = READ_LATENCY == 0 ? addr_ok : la_ok;
  assign ram_data = drive ? (rd_ok ? mem[rd_addr[IW-1:0]] : '1) : 'z;
  // posted byte-masked writes; the array is intentionally left untouched by reset
  always_ff @(posedge clk)
    if (wr_req && addr_ok)
      for (int i = 0; i < NBYTES; i++)
        if (!ram_be_n[i]) mem[ram_addr[IW-1:0]][8*i +: 8] <= ram_data[8*i +: 8];
  // read FSM state, counters and sticky protocol flags
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= IDLE;
      la         <= '0;
      cnt        <= '0;
      rd_count   <= '0;
      wr_count   <= '0;
      contention <= 1'b0;
      range_err  <= 1'b0;
    end else begin
      state <= nxt_state;
      la    <= nxt_la;
      cnt   <= nxt_cnt;
      if (rd_inc && rd_count != '1) rd_count <= rd_count + CNT_WIDTH'(1);
      if (wr_req && wr_count != '1) wr_count <= wr_count + CNT_WIDTH'(1);
      if (clash) contention <= 1'b1;
      if ((rd_req || wr_req) && !addr_ok) range_err <= 1'b1;
    end
  // next read state: any non-read cycle idles, a new address restarts the wait, a held address counts down
  always_comb begin
    nxt_state = state;
    nxt_la    = la;
    nxt_cnt   = cnt;
    fresh     = rd_req && (state == IDLE || ram_addr != la);
    if (!rd_req) nxt_state = IDLE;
    else if (fresh) begin
      nxt_la  = ram_addr;
      nxt_cnt = CW'(READ_LATENCY - 1);
      if (READ_LATENCY > 1) nxt_state = WAIT;
      else nxt_state = DRIVE;
    end else if (state == WAIT) begin
      nxt_cnt = cnt - CW'(1);
      if (cnt == CW'(1)) nxt_state = DRIVE;
    end
  end
  // bus drive is requalified continuously so oe_n/ce_n/reset release the bus without a clock
  always_comb begin
    rd_inc = nxt_state == DRIVE && (state != DRIVE || ram_addr != la);
    drive  = rst_n && rd_req && (READ_LATENCY == 0 || state == DRIVE);
  end
endmodule

// File: tb/tb_sram_model_param.sv
// tb_sram_model_param: directed checks of three model configurations sharing one bus stimulus
module tb_sram_model_param;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [11:0] addr = '0;
  logic [3:0] be_n = '1;
  logic ce_n = 1'b1, oe_n = 1'b1, we_n = 1'b1, wen = 1'b0;
  logic [31:0] wd = '0;
  wire [31:0] da, db;
  wire [15:0] dc;
  logic [15:0] a_rd, a_wr, b_rd, b_wr;
  logic [1:0] c_rd, c_wr;
  logic a_con, a_rng, b_con, b_rng, c_con, c_rng;
  int n_chk = 0, n_err = 0;
  assign da = wen ? wd : 'z;
  assign db = wen ? wd : 'z;
  assign dc = wen ? wd[15:0] : 'z;
  always #5 clk = ~clk;
  sram_model_param #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .DEPTH(1024), .READ_LATENCY(0), .CNT_WIDTH(16)) u_a (
    .clk(clk), .rst_n(rst_n), .ram_data(da), .ram_addr(addr), .ram_be_n(be_n), .ram_ce_n(ce_n),
    .ram_oe_n(oe_n), .ram_we_n(we_n), .rd_count(a_rd), .wr_count(a_wr), .contention(a_con), .range_err(a_rng));
  sram_model_param #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .DEPTH(1024), .READ_LATENCY(3), .CNT_WIDTH(16)) u_b (
    .clk(clk), .rst_n(rst_n), .ram_data(db), .ram_addr(addr), .ram_be_n(be_n), .ram_ce_n(ce_n),
    .ram_oe_n(oe_n), .ram_we_n(we_n), .rd_count(b_rd), .wr_count(b_wr), .contention(b_con), .range_err(b_rng));
  sram_model_param #(.DATA_WIDTH(16), .ADDR_WIDTH(12), .DEPTH(1024), .READ_LATENCY(3), .CNT_WIDTH(2)) u_c (
    .clk(clk), .rst_n(rst_n), .ram_data(dc), .ram_addr(addr), .ram_be_n(be_n[1:0]), .ram_ce_n(ce_n),
    .ram_oe_n(oe_n), .ram_we_n(we_n), .rd_count(c_rd), .wr_count(c_wr), .contention(c_con), .range_err(c_rng));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] b);
    @(negedge clk);
    addr = a; wd = d; be_n = b; wen = 1'b1; ce_n = 1'b0; oe_n = 1'b1; we_n = 1'b0;
    @(negedge clk);
    ce_n = 1'b1; we_n = 1'b1; wen = 1'b0; be_n = '1;
  endtask
  task automatic rd(input logic [11:0] a);
    @(negedge clk);
    addr = a; ce_n = 1'b0; oe_n = 1'b0; we_n = 1'b1;
    #1;
  endtask
  task automatic idle();
    @(negedge clk);
    ce_n = 1'b1; oe_n = 1'b1; we_n = 1'b1; be_n = '1;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    #12;
    chk("rst_a_rd", 32'(a_rd), 0);
    chk("rst_a_wr", 32'(a_wr), 0);
    chk("rst_b_con", 32'(b_con), 0);
    chk("rst_c_rng", 32'(c_rng), 0);
    chk("rst_da_z", 32'(da === 32'hzzzz_zzzz), 1);
    @(negedge clk);
    rst_n = 1'b1;
    wr(12'd5, 32'hDEAD_BEEF, 4'b0000);
    wr(12'd5, 32'h0000_00AA, 4'b1110);
    chk("a_wr_2", 32'(a_wr), 2);
    chk("c_wr_2", 32'(c_wr), 2);
    rd(12'd5);
    chk("a_comb_rd", da, 32'hDEAD_BEAA);
    chk("b_idle_z", 32'(db === 32'hzzzz_zzzz), 1);
    tick();
    chk("a_rd_1", 32'(a_rd), 1);
    chk("b_rd_0", 32'(b_rd), 0);
    idle();
    wr(12'd7, 32'h1234_5678, 4'b0000);
    wr(12'd9, 32'hCAFE_F00D, 4'b0000);
    chk("c_wr_sat", 32'(c_wr), 3);
    chk("a_wr_4", 32'(a_wr), 4);
    rd(12'd7);
    tick();
    chk("b_lat_e0_z", 32'(db === 32'hzzzz_zzzz), 1);
    tick();
    chk("b_lat_e1_z", 32'(db === 32'hzzzz_zzzz), 1);
    tick();
    chk("b_lat_e2_data", db, 32'h1234_5678);
    chk("c_lat_e2_data", 32'(dc), 32'h0000_5678);
    chk("b_rd_1", 32'(b_rd), 1);
    chk("a_rd_2", 32'(a_rd), 2);
    #2;
    oe_n = 1'b1;
    #1;
    chk("b_oe_rise_z", 32'(db === 32'hzzzz_zzzz), 1);
    chk("c_oe_rise_z", 32'(dc === 16'hzzzz), 1);
    idle();
    rd(12'd7);
    tick();
    @(negedge clk);
    addr = 12'd9;
    tick();
    tick();
    chk("b_chg_e2_z", 32'(db === 32'hzzzz_zzzz), 1);
    chk("b_chg_e2_cnt", 32'(b_rd), 1);
    tick();
    chk("b_chg_e3_data", db, 32'hCAFE_F00D);
    chk("b_chg_cnt", 32'(b_rd), 2);
    chk("a_rd_4", 32'(a_rd), 4);
    chk("a_rd9", da, 32'hCAFE_F00D);
    idle();
    wr(12'd2, 32'h1111_2222, 4'b0000);
    @(negedge clk);
    addr = 12'd2; wd = 32'h0000_0055; wen = 1'b1; be_n = 4'b0000; ce_n = 1'b0; oe_n = 1'b0; we_n = 1'b0;
    tick();
    chk("a_clash_con", 32'(a_con), 1);
    chk("a_clash_wr", 32'(a_wr), 5);
    wen = 1'b0;
    #1;
    chk("a_clash_z", 32'(da === 32'hzzzz_zzzz), 1);
    chk("b_clash_z", 32'(db === 32'hzzzz_zzzz), 1);
    idle();
    rd(12'd2);
    chk("a_clash_mem", da, 32'h1111_2222);
    tick();
    idle();
    chk("c_pre_rng", 32'(c_rng), 0);
    wr(12'd0, 32'h0BAD_C0DE, 4'b0000);
    wr(12'd1024, 32'h9999_9999, 4'b0000);
    chk("a_rng", 32'(a_rng), 1);
    chk("b_rng", 32'(b_rng), 1);
    chk("a_wr_7", 32'(a_wr), 7);
    rd(12'd1500);
    chk("a_oor_ones", da, 32'hFFFF_FFFF);
    tick();
    @(negedge clk);
    addr = 12'd0;
    #1;
    chk("a_no_alias", da, 32'h0BAD_C0DE);
    tick();
    chk("a_rd_7", 32'(a_rd), 7);
    idle();
    chk("a_con_sticky", 32'(a_con), 1);
    rd(12'd5);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("c_rst_z", 32'(dc === 16'hzzzz), 1);
    chk("a_rst_z", 32'(da === 32'hzzzz_zzzz), 1);
    chk("c_rst_rd", 32'(c_rd), 0);
    chk("c_rst_wr", 32'(c_wr), 0);
    chk("a_rst_con", 32'(a_con), 0);
    chk("a_rst_rng", 32'(a_rng), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    chk("c_post_rst_z", 32'(dc === 16'hzzzz), 1);
    tick();
    chk("c_post_rst_data", 32'(dc), 32'h0000_BEAA);
    chk("c_post_rst_rd", 32'(c_rd), 1);
    chk("b_post_rst_data", db, 32'hDEAD_BEAA);
    chk("a_post_rst_rd", 32'(a_rd), 1);
    idle();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
